// File: rtl/branchpred.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and a registered mispredict flag.
// Optional statistics counters are enabled by defining BRANCHPRED_STATS_EN.
module branchpred #(
  parameter int unsigned n       = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [n-1:0] i_pcf,
  output logic         o_predtaken,
  output logic [n-1:0] o_predtarget,
  input  logic         i_upd,
  input  logic [n-1:0] i_updpc,
  input  logic         i_updbrnch,
  input  logic [n-1:0] i_updtarget,
  input  logic         i_updpred,
  input  logic [n-1:0] i_updptarget,
  output logic         o_mispredict,
  output logic [n-1:0] o_brcount,
  output logic [n-1:0] o_mpcount
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = n - IDXW - 2;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [n-1:0]    r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic            r_mispredict;

  logic [IDXW-1:0] w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic            w_lk_hit;
  logic [IDXW-1:0] w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic            w_up_hit;
  logic            w_mp;
  logic            w_unused_ok;

  assign w_lk_idx = i_pcf[IDXW+1:2];
  assign w_lk_tag = i_pcf[n-1:IDXW+2];
  assign w_up_idx = i_updpc[IDXW+1:2];
  assign w_up_tag = i_updpc[n-1:IDXW+2];
  assign w_unused_ok = &{1'b0, i_pcf[1:0], i_updpc[1:0]};

  // Lookup reads the pre-update table; there is no bypass from the update port.
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_predtaken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_predtarget = w_lk_hit ? r_target[w_lk_idx] : i_pcf + n'(4);

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_mp     = (i_updbrnch != i_updpred) |
                    (i_updbrnch & i_updpred & (i_updtarget != i_updptarget));

  // Table training and mispredict flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_mispredict <= 1'b0;
    end else begin
      r_mispredict <= i_upd & w_mp;
      if (i_upd) begin
        if (w_up_hit) begin
          if (i_updbrnch) begin
            if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
            r_target[w_up_idx] <= i_updtarget;
          end else if (r_ctr[w_up_idx] != 2'b00) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
          end
        end else if (i_updbrnch) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= i_updtarget;
          r_ctr[w_up_idx]    <= 2'b10;
        end
      end
    end
  end

  assign o_mispredict = r_mispredict;

`ifdef BRANCHPRED_STATS_EN
  logic [n-1:0] r_brcount;
  logic [n-1:0] r_mpcount;

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_brcount <= '0;
      r_mpcount <= '0;
    end else if (i_upd) begin
      if (r_brcount != '1) r_brcount <= r_brcount + n'(1);
      if (w_mp && (r_mpcount != '1)) r_mpcount <= r_mpcount + n'(1);
    end
  end

  assign o_brcount = r_brcount;
  assign o_mpcount = r_mpcount;
`else
  assign o_brcount = '0;
  assign o_mpcount = '0;
`endif

endmodule

// File: tb/tb_branchpred.sv
// Self-checking bench for branchpred; mispredict expectations flow through a scoreboard queue.
module tb_branchpred;

  logic        clk;
  logic        rst;
  logic [31:0] pcf;
  logic        predtaken;
  logic [31:0] predtarget;
  logic        upd;
  logic [31:0] updpc;
  logic        updbrnch;
  logic [31:0] updtarget;
  logic        updpred;
  logic [31:0] updptarget;
  logic        mispredict;
  logic [31:0] brcount;
  logic [31:0] mpcount;

  int   n_cmp = 0;
  int   n_mis = 0;
  logic sb_q [$];
  logic e;
  logic [31:0] m_br = 0;
  logic [31:0] m_mp = 0;

  branchpred dut (
    .i_clock(clk), .i_reset(rst), .i_pcf(pcf),
    .o_predtaken(predtaken), .o_predtarget(predtarget),
    .i_upd(upd), .i_updpc(updpc), .i_updbrnch(updbrnch),
    .i_updtarget(updtarget), .i_updpred(updpred), .i_updptarget(updptarget),
    .o_mispredict(mispredict), .o_brcount(brcount), .o_mpcount(mpcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_br();
`ifdef BRANCHPRED_STATS_EN
    return m_br;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mp();
`ifdef BRANCHPRED_STATS_EN
    return m_mp;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one update and push its expected mispredict bit.
  task automatic set_upd(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                         input logic pr, input logic [31:0] ptgt);
    logic mp;
    upd = 1'b1; updpc = pc; updbrnch = br; updtarget = tgt; updpred = pr; updptarget = ptgt;
    mp = (br != pr) || (br && pr && (tgt != ptgt));
    sb_q.push_back(mp);
    m_br = m_br + 1;
    if (mp) m_mp = m_mp + 1;
  endtask

  task automatic upd_cycle(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                           input logic pr, input logic [31:0] ptgt);
    set_upd(pc, br, tgt, pr, ptgt);
    tick();
    upd = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    sb_q.delete();
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pcf = 32'h100; upd = 1'b0; updpc = 0; updbrnch = 0;
    updtarget = 0; updpred = 0; updptarget = 0;
    #2;
    n_cmp++; if (mispredict !== 1'b0) begin n_mis++; $display("FAIL reset_mp: got %b want 0", mispredict); end
    n_cmp++; if (brcount !== 32'd0 || mpcount !== 32'd0) begin n_mis++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", brcount, mpcount); end
    @(negedge clk) rst = 1'b0;
    tick();
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h104) begin n_mis++; $display("FAIL cold_lookup: got %b %h want 0 00000104", predtaken, predtarget); end
  endtask

  task automatic test_train();
    upd_cycle(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    e = sb_q.pop_front();
    n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL train_mp: got %b want %b", mispredict, e); end
    pcf = 32'h100; #1;
    n_cmp++; if (predtaken !== 1'b1 || predtarget !== 32'h80) begin n_mis++; $display("FAIL train_hit: got %b %h want 1 00000080", predtaken, predtarget); end
    tick();
    n_cmp++; if (mispredict !== 1'b0) begin n_mis++; $display("FAIL mp_clear: got %b want 0", mispredict); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      upd_cycle(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      e = sb_q.pop_front();
      n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL sat_mp%0d: got %b want %b", i, mispredict, e); end
    end
    pcf = 32'h100; #1;
    n_cmp++; if (predtaken !== 1'b1) begin n_mis++; $display("FAIL sat_hi: got %b want 1", predtaken); end
    upd_cycle(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    e = sb_q.pop_front();
    n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL hyst_mp: got %b want %b", mispredict, e); end
    n_cmp++; if (predtaken !== 1'b1 || predtarget !== 32'h80) begin n_mis++; $display("FAIL hyst_keep: got %b %h want 1 00000080", predtaken, predtarget); end
    upd_cycle(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    e = sb_q.pop_front();
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h80) begin n_mis++; $display("FAIL hyst_flip: got %b %h want 0 00000080", predtaken, predtarget); end
    // Drive to 00 and one further NT, then one taken must still predict not-taken.
    for (int i = 0; i < 2; i++) begin
      upd_cycle(32'h100, 1'b0, 32'h80, 1'b0, 32'h80);
      e = sb_q.pop_front();
      n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL sat_lo_mp%0d: got %b want %b", i, mispredict, e); end
    end
    upd_cycle(32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    e = sb_q.pop_front();
    n_cmp++; if (predtaken !== 1'b0) begin n_mis++; $display("FAIL sat_lo: got %b want 0", predtaken); end
  endtask

  task automatic test_alias();
    upd_cycle(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    e = sb_q.pop_front();
    pcf = 32'h100; #1;
    n_cmp++; if (predtaken !== 1'b1) begin n_mis++; $display("FAIL alias_pre: got %b want 1", predtaken); end
    upd_cycle(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    e = sb_q.pop_front();
    n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL alias_mp: got %b want %b", mispredict, e); end
    pcf = 32'h100; #1;
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h104) begin n_mis++; $display("FAIL alias_evict: got %b %h want 0 00000104", predtaken, predtarget); end
    pcf = 32'h140; #1;
    n_cmp++; if (predtaken !== 1'b1 || predtarget !== 32'h200) begin n_mis++; $display("FAIL alias_new: got %b %h want 1 00000200", predtaken, predtarget); end
    upd_cycle(32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    e = sb_q.pop_front();
    n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL tgt_mp: got %b want %b", mispredict, e); end
    n_cmp++; if (predtarget !== 32'h240) begin n_mis++; $display("FAIL tgt_upd: got %h want 00000240", predtarget); end
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    pcf = 32'h100;
    set_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    n_cmp++; if (predtaken !== 1'b0) begin n_mis++; $display("FAIL same_pre: got %b want 0", predtaken); end
    tick();
    upd = 1'b0;
    n_cmp++; if (predtaken !== 1'b1) begin n_mis++; $display("FAIL same_post: got %b want 1", predtaken); end
    e = sb_q.pop_front();
    n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL same_mp: got %b want %b", mispredict, e); end
  endtask

  task automatic test_back_to_back();
    logic b_br [3] = '{1'b1, 1'b0, 1'b0};
    logic b_pr [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h108, b_br[i], 32'h400, b_pr[i], 32'h400);
      tick();
      e = sb_q.pop_front();
      n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL b2b_mp%0d: got %b want %b", i, mispredict, e); end
    end
    upd = 1'b0;
    pcf = 32'h108; #1;
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h400) begin n_mis++; $display("FAIL b2b_state: got %b %h want 0 00000400", predtaken, predtarget); end
    tick();
    n_cmp++; if (mispredict !== 1'b0) begin n_mis++; $display("FAIL b2b_clear: got %b want 0", mispredict); end
  endtask

  task automatic test_stats();
    logic s_br [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic s_pr [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      upd_cycle(32'h10C, s_br[i], 32'h500, s_pr[i], 32'h500);
      e = sb_q.pop_front();
      n_cmp++; if (mispredict !== e) begin n_mis++; $display("FAIL stats_mp%0d: got %b want %b", i, mispredict, e); end
    end
    n_cmp++; if (brcount !== exp_br()) begin n_mis++; $display("FAIL brcount: got %0d want %0d", brcount, exp_br()); end
    n_cmp++; if (mpcount !== exp_mp()) begin n_mis++; $display("FAIL mpcount: got %0d want %0d", mpcount, exp_mp()); end
    // Reset lands while an update is pending; nothing it carried may survive.
    set_upd(32'h10C, 1'b1, 32'h500, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (brcount !== 32'd0 || mpcount !== 32'd0) begin n_mis++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", brcount, mpcount); end
    pcf = 32'h10C; #1;
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h110) begin n_mis++; $display("FAIL mid_rst_miss: got %b %h want 0 00000110", predtaken, predtarget); end
    upd = 1'b0;
    sb_q.delete();
    m_br = 0;
    m_mp = 0;
    @(negedge clk) rst = 1'b0;
    tick();
    pcf = 32'h108; #1;
    n_cmp++; if (predtaken !== 1'b0 || predtarget !== 32'h10C || mispredict !== 1'b0) begin n_mis++; $display("FAIL post_rst: got %b %h %b want 0 0000010c 0", predtaken, predtarget, mispredict); end
    n_cmp++; if (brcount !== 32'd0) begin n_mis++; $display("FAIL post_rst_cnt: got %0d want 0", brcount); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branchpred.md
# branchpred

Dynamic branch predictor for the RISC-V core: a direct-mapped branch target buffer with 2-bit saturating counters. The fetch stage looks up the current PC to get a taken/target prediction. The execute stage feeds back the resolved outcome produced by the branch comparator (`brnch`) to train the table and raise a registered mispredict flag. It sits beside the PC logic in fetch, and its update port is driven from execute.

## Interface
- `n`, 32, datapath / PC width
- `ENTRIES`, 16, table entries, power of two ≥ 2; `IDXW = $clog2(ENTRIES)`
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pcf`  in  n  fetch PC to look up
- `predtaken`  out  1  prediction for `pcf`: branch taken
- `predtarget`  out  n  predicted target for `pcf`
- `upd`  in  1  single-cycle update strobe from execute (one resolved conditional branch)
- `updpc`  in  n  PC of the resolved branch
- `updbrnch`  in  1  resolved outcome (`brnch` from comparator)
- `updtarget`  in  n  computed branch target
- `updpred`  in  1  `predtaken` originally issued for this branch
- `updptarget`  in  n  `predtarget` originally issued for this branch
- `mispredict`  out  1  registered: last update disagreed with its prediction
- `brcount`  out  n  resolved-branch counter (see Configuration)
- `mpcount`  out  n  mispredict counter (see Configuration)

## Operation
- Index = `pc[IDXW+1:2]`. Tag = `pc[n-1:IDXW+2]`. `pc[1:0]` is ignored.
- Per-entry state: `valid`, `tag`, `target[n-1:0]`, `ctr[1:0]`. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from the current table state:
  - hit = `valid & (tag == pcf tag)`
  - `predtaken = hit & ctr[1]`
  - `predtarget = hit ? target : pcf + 4`
- Update on a rising edge with `upd=1`:
  - Hit, taken: `ctr` increments, saturating at 11; `target <= updtarget`.
  - Hit, not taken: `ctr` decrements, saturating at 00; `target` unchanged.
  - Miss, taken: allocate the entry, overwriting any aliasing entry. Set `valid=1`, `tag`, `target <= updtarget`, `ctr <= 10`.
  - Miss, not taken: no table change.
- Mispredict is computed from the update inputs: `(updbrnch != updpred) | (updbrnch & updpred & (updtarget != updptarget))`. It is registered into `mispredict`.
- With `upd=0`, no table write occurs and `mispredict` clears to 0.

## Timing
- Reset, asynchronous: all `valid=0`, all `ctr=01`, `tag` and `target` cleared to 0, `mispredict=0`, `brcount=0`, `mpcount=0`.
- Lookup latency: 0 cycles, combinational from `pcf`.
- Update latency: the table changes at the edge sampling `upd`. Lookups in the following cycle see the new state.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update state (no bypass).
- `mispredict` is valid exactly one cycle after the `upd` edge and holds for one cycle per update.
- Back-to-back updates (`upd` high every cycle) are supported, one per cycle. Each update reads state already written by the previous one.
- Reset asserted mid-stream discards all learned state immediately. The first cycle after deassertion behaves as post-reset.

## Configuration
- `BRANCHPRED_STATS_EN` defined:
  - `brcount` increments on every `upd`.
  - `mpcount` increments on every update whose mispredict term is 1.
  - Both saturate at all-ones and never wrap.
- `BRANCHPRED_STATS_EN` undefined: no counter flops; `brcount` and `mpcount` are tied to 0.

## Test plan
- Cold lookup: after reset, `pcf=0x100` -> `predtaken=0`, `predtarget=0x104`.
- Train and hit:
  - Update `updpc=0x100`, `updbrnch=1`, `updtarget=0x80`, `updpred=0` -> next cycle `mispredict=1`.
  - Then `pcf=0x100` -> `predtaken=1`, `predtarget=0x80` (`ctr=10`).
- Saturation and hysteresis:
  - Three more taken updates at 0x100 -> `ctr=11`, with `mispredict=0` for the updates issued with `updpred=1`, `updptarget=0x80`.
  - One not-taken update -> `predtaken` still 1 (`ctr=10`).
  - A second not-taken update -> `predtaken=0`.
- Alias eviction:
  - Entry at 0x100 trained.
  - Taken update at `updpc=0x140` (same index 0, different tag) with target 0x200 -> `pcf=0x100` misses (`predtarget=0x104`), `pcf=0x140` gives `predtarget=0x200`.
- Same-cycle lookup and update:
  - `pcf=0x100` while `upd` trains 0x100 from empty -> that cycle `predtaken=0`, next cycle `predtaken=1`.
- Stats and reset (with `BRANCHPRED_STATS_EN`):
  - 5 updates with 2 mispredicts -> `brcount=5`, `mpcount=2`.
  - Assert `reset` mid-sequence -> both counters read 0 immediately and all lookups miss.
